// File: rtl/tt_um_ks_accum_sub_pkg.sv
// ---------------------------------------------------------------------------
// tt_um_ks_accum_sub_pkg: opcodes, FSM encoding and uio bit map. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tt_um_ks_accum_sub_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int STROBE_BIT = 2;
  localparam int BUSY_BIT   = 3;
  localparam int DONE_BIT   = 4;
  localparam int CARRY_BIT  = 5;
  localparam int ZERO_BIT   = 6;
  localparam int OVF_BIT    = 7;

  localparam logic [7:0] UIO_OE_VAL = 8'hF8;

endpackage

`default_nettype wire

// File: rtl/tt_um_ks_accum_sub_ks_add4_cin.sv
// ---------------------------------------------------------------------------
// ks_add4_cin: combinational 4-bit Kogge-Stone adder with carry-in. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ks_add4_cin (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] g0;
  logic [3:0] g1;
  logic [3:2] p1;
  logic [3:0] g2;

  assign p = a ^ b;
  assign g = a & b;

  // Carry-in is folded into the bit-0 generate so the prefix tree needs no extra column.
  assign g0 = {g[3:1], g[0] | (p[0] & cin)};

  assign g1[0] = g0[0];
  generate
    for (genvar i = 1; i < 4; i++) begin : g_lvl1
      assign g1[i] = g0[i] | (p[i] & g0[i-1]);
    end
    for (genvar i = 2; i < 4; i++) begin : g_lvl1_p
      assign p1[i] = p[i] & p[i-1];
    end
    for (genvar i = 0; i < 4; i++) begin : g_lvl2
      if (i >= 2) begin : g_span
        assign g2[i] = g1[i] | (p1[i] & g1[i-2]);
      end else begin : g_pass
        assign g2[i] = g1[i];
      end
    end
  endgenerate

  assign sum  = p ^ {g2[2:0], cin};
  assign cout = g2[3];

endmodule

`default_nettype wire

// File: rtl/tt_um_ks_accum_sub.sv
// ---------------------------------------------------------------------------
// tt_um_ks_accum_sub: strobed 8-bit accumulator, two nibble passes through one adder. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tt_um_ks_accum_sub #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  import tt_um_ks_accum_sub_pkg::*;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   strobe_prev;
  logic                   accept;
  state_t                 state;
  state_t                 state_next;
  logic                   busy;
  logic                   done;
  logic [7:0]             acc;
  logic [7:0]             opa;
  logic [7:0]             opb;
  logic                   op_cin;
  logic                   nib_carry;
  logic                   carry;
  logic                   zero;
  logic                   ovf;
  logic [7:0]             eff_a;
  logic [7:0]             eff_b;
  logic                   eff_cin;
  logic [3:0]             add_a;
  logic [3:0]             add_b;
  logic                   add_cin;
  logic [3:0]             add_sum;
  logic                   add_cout;
  logic                   unused_inputs;

  assign unused_inputs = &{1'b0, ena, uio_in[7:3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      strobe_prev <= 1'b0;
    end else begin
      sync_q[0] <= uio_in[STROBE_BIT];
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      strobe_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    eff_a   = acc;
    eff_b   = ui_in;
    eff_cin = 1'b0;
    case (uio_in[1:0])
      OP_SUB: begin
        eff_b   = ~ui_in;
        eff_cin = 1'b1;
      end
      OP_LOAD:  eff_a = 8'h00;
      OP_CLEAR: begin
        eff_a = 8'h00;
        eff_b = 8'h00;
      end
      default: eff_cin = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = sync_q[SYNC_STAGES-1] & ~strobe_prev;
        if (accept) state_next = ST_LO;
      end
      ST_LO: begin
        busy       = 1'b1;
        state_next = ST_HI;
      end
      ST_HI: begin
        busy       = 1'b1;
        state_next = ST_DONE;
      end
      default: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  // The single adder sees the low nibble in LO and the high nibble in HI.
  assign add_a   = (state == ST_HI) ? opa[7:4] : opa[3:0];
  assign add_b   = (state == ST_HI) ? opb[7:4] : opb[3:0];
  assign add_cin = (state == ST_HI) ? nib_carry : op_cin;

  ks_add4_cin u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= 8'h00;
      opa       <= 8'h00;
      opb       <= 8'h00;
      op_cin    <= 1'b0;
      nib_carry <= 1'b0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (accept) begin
        opa    <= eff_a;
        opb    <= eff_b;
        op_cin <= eff_cin;
      end
      if (state == ST_LO) begin
        acc[3:0]  <= add_sum;
        nib_carry <= add_cout;
      end
      if (state == ST_HI) begin
        acc[7:4] <= add_sum;
        carry    <= add_cout;
        zero     <= ({add_sum, acc[3:0]} == 8'h00);
        ovf      <= (opa[7] == opb[7]) && (add_sum[3] != opa[7]);
      end
    end
  end

  always_comb begin
    uio_out            = 8'h00;
    uio_out[BUSY_BIT]  = busy;
    uio_out[DONE_BIT]  = done;
    uio_out[CARRY_BIT] = carry;
    uio_out[ZERO_BIT]  = zero;
    uio_out[OVF_BIT]   = ovf;
  end

  assign uo_out = acc;
  assign uio_oe = UIO_OE_VAL;

endmodule

`default_nettype wire

// File: tb/tb_tt_um_ks_accum_sub.sv
// ---------------------------------------------------------------------------
// tb_tt_um_ks_accum_sub: directed vector table plus timing, ignore and abort sequences. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tt_um_ks_accum_sub;

  import tt_um_ks_accum_sub_pkg::*;

  typedef struct {
    logic [1:0] op;
    logic [7:0] b;
    logic [7:0] acc;
    logic       c;
    logic       z;
    logic       v;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  vec_t vecs[16];

  always #5 clk = ~clk;

  tt_um_ks_accum_sub #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [7:0] b);
    ui_in  = b;
    uio_in = {5'b00000, 1'b1, op};
  endtask

  task automatic wait_done(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (uio_out[DONE_BIT] === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic release_strobe();
    uio_in[STROBE_BIT] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_result(input string tag, input logic [7:0] acc,
                              input logic c, input logic z, input logic v);
    check({tag, "_acc"}, {8'h00, uo_out}, {8'h00, acc});
    check({tag, "_flags"}, {13'h0, uio_out[CARRY_BIT], uio_out[ZERO_BIT], uio_out[OVF_BIT]},
          {13'h0, c, z, v});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic       seen;
    logic [5:0] busy_exp;
    logic [5:0] done_exp;
    logic [5:0] busy_got;
    logic [5:0] done_got;
    logic [7:0] acc_mid;
    logic [7:0] acc_hold;
    int         ndone;

    vecs[0]  = '{OP_ADD,   8'hC4, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{OP_LOAD,  8'h50, 8'h50, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{OP_SUB,   8'h70, 8'hE0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{OP_LOAD,  8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{OP_ADD,   8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{OP_LOAD,  8'h80, 8'h80, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{OP_SUB,   8'h01, 8'h7F, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{OP_CLEAR, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{OP_ADD,   8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{OP_ADD,   8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{OP_SUB,   8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{OP_LOAD,  8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{OP_ADD,   8'h01, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{OP_SUB,   8'h20, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{OP_ADD,   8'h90, 8'h80, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{OP_LOAD,  8'h00, 8'h00, 1'b0, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_uo_out", {8'h00, uo_out}, 16'h0000);
    check("rst_uio_out", {8'h00, uio_out}, 16'h0000);
    check("rst_uio_oe", {8'h00, uio_oe}, 16'h00F8);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // LOAD 0x3C with cycle-accurate busy/done/ACC tracking, k = sample after E_k
    busy_exp = 6'b001100;
    done_exp = 6'b010000;
    acc_mid  = 8'h00;
    start_cmd(OP_LOAD, 8'h3C);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      busy_got[k] = uio_out[BUSY_BIT];
      done_got[k] = uio_out[DONE_BIT];
      if (k == 3) acc_mid = uo_out;
      if (k == 4) check_result("load3c", 8'h3C, 1'b0, 1'b0, 1'b0);
    end
    check("timing_busy", {10'h0, busy_got}, {10'h0, busy_exp});
    check("timing_done", {10'h0, done_got}, {10'h0, done_exp});
    check("timing_mid_acc", {8'h00, acc_mid}, 16'h000C);
    release_strobe();

    // Vector table
    foreach (vecs[i]) begin
      start_cmd(vecs[i].op, vecs[i].b);
      wait_done(seen);
      check($sformatf("vec%0d_done", i), {15'h0, seen}, 16'h0001);
      check_result($sformatf("vec%0d", i), vecs[i].acc, vecs[i].c, vecs[i].z, vecs[i].v);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), {15'h0, uio_out[DONE_BIT]}, 16'h0000);
      release_strobe();
    end

    // Strobe re-edge and operand change while busy are ignored
    start_cmd(OP_LOAD, 8'h10);
    wait_done(seen);
    release_strobe();
    start_cmd(OP_ADD, 8'h22);
    @(negedge clk);
    uio_in[STROBE_BIT] = 1'b0;
    @(negedge clk);
    uio_in[STROBE_BIT] = 1'b1;
    @(negedge clk);
    check("ign_busy_lo", {15'h0, uio_out[BUSY_BIT]}, 16'h0001);
    ui_in       = 8'hFF;
    uio_in[1:0] = OP_SUB;
    ndone    = 0;
    acc_hold = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (uio_out[DONE_BIT] === 1'b1) begin
        ndone++;
        acc_hold = uo_out;
      end
    end
    check("ign_done_count", ndone[15:0], 16'd1);
    check("ign_acc", {8'h00, acc_hold}, 16'h0032);
    check("ign_acc_after", {8'h00, uo_out}, 16'h0032);
    release_strobe();

    // Reset pulse during HI aborts the command
    start_cmd(OP_LOAD, 8'h55);
    repeat (4) @(negedge clk);
    check("abort_in_hi_busy", {15'h0, uio_out[BUSY_BIT]}, 16'h0001);
    check("abort_mid_acc", {8'h00, uo_out}, 16'h0035);
    rst_n  = 1'b0;
    uio_in = 8'h00;
    #1;
    check("abort_uo_out", {8'h00, uo_out}, 16'h0000);
    check("abort_uio_out", {8'h00, uio_out}, 16'h0000);
    check("abort_uio_oe", {8'h00, uio_oe}, 16'h00F8);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (uio_out[DONE_BIT] === 1'b1) ndone++;
    end
    check("abort_no_done", ndone[15:0], 16'd0);
    check("abort_acc_stays", {8'h00, uo_out}, 16'h0000);

    start_cmd(OP_LOAD, 8'hAA);
    wait_done(seen);
    check("post_load_done", {15'h0, seen}, 16'h0001);
    check_result("post_loadaa", 8'hAA, 1'b0, 1'b0, 1'b0);
    release_strobe();
    start_cmd(OP_CLEAR, 8'h33);
    wait_done(seen);
    check("post_clear_done", {15'h0, seen}, 16'h0001);
    check_result("post_clear", 8'h00, 1'b0, 1'b1, 1'b0);
    release_strobe();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tt_um_ks_accum_sub.md
TT_UM_KS_ACCUM_SUB -- requirements
Module: tt_um_ks_accum_sub

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops on the strobe input.
REQ-003 Port clk SHALL be input, width 1: rising-edge clock.
REQ-004 Port rst_n SHALL be input, width 1: asynchronous active-low reset.
REQ-005 Port ena SHALL be input, width 1: always 1 while powered; ignored.
REQ-006 Port ui_in SHALL be input, width 8: operand B.
REQ-007 Port uio_in SHALL be input, width 8: [1:0] opcode (00 LOAD, 01 ADD, 10 SUB, 11 CLEAR), [2] strobe; [7:3] ignored.
REQ-008 Port uo_out SHALL be output, width 8: accumulator ACC.
REQ-009 Port uio_out SHALL be output, width 8: [2:0]=0, [3] busy, [4] done, [5] carry, [6] zero, [7] overflow.
REQ-010 Port uio_oe SHALL be output, width 8: constant 0xF8.

Function
REQ-011 The strobe SHALL pass through SYNC_STAGES flops, and a command SHALL be accepted on the edge where the synchronized strobe is 1, its previous value is 0, and the state is IDLE.
REQ-012 At acceptance, the block SHALL capture the opcode and ui_in; the effective operands SHALL be ADD: ACC+B+0, SUB: ACC+~B+1, LOAD: 0+B+0, CLEAR: 0+0+0.
REQ-013 The state machine SHALL have the states IDLE -> LO -> HI -> DONE -> IDLE, with exactly one cycle in each non-IDLE state.
REQ-014 In LO, the block SHALL compute the low nibble through the 4-bit prefix adder, write ACC[3:0], and register the nibble carry.
REQ-015 In HI, the block SHALL compute the high nibble using the registered carry as carry-in, write ACC[7:4], and update the flags.
REQ-016 Carry SHALL equal the carry out of bit 7; for SUB, carry=1 means no borrow.
REQ-017 Overflow SHALL equal (a7 == b'7) AND (s7 != a7), where b' is the effective second operand; overflow is therefore 0 for LOAD and CLEAR.
REQ-018 Zero SHALL equal (final ACC == 0).
REQ-019 Busy SHALL be 1 in LO and HI; done SHALL be 1 only in DONE, as a single-cycle pulse.
REQ-020 With the strobe driven high before edge E0 and SYNC_STAGES=2, the command SHALL be accepted at E2, ACC[3:0] SHALL update at E3, and ACC[7:4] plus the flags SHALL update at E4; done SHALL be high from E4 to E5.
REQ-021 Between E3 and E4, uo_out SHALL show the new low nibble and the old high nibble; the result is valid only when done=1 or the state is IDLE.
REQ-022 Strobe rising edges that occur outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-023 A strobe held high SHALL produce only one command; a new command requires the strobe to return low first.
REQ-024 ui_in and the opcode SHALL be sampled only at acceptance; later changes SHALL have no effect on the command in flight.
REQ-025 Arithmetic SHALL wrap modulo 256.

Reset
REQ-026 On rst_n=0, the block SHALL asynchronously set ACC=0x00, carry=0, zero=0, overflow=0, state=IDLE, and all synchronizer and edge flops to 0.
REQ-027 Reset asserted mid-operation (LO, HI or DONE) SHALL abort the command; no partial result SHALL persist after reset.
REQ-028 In reset, uio_oe SHALL be 0xF8, uio_out[2:0] SHALL be 0, and busy and done SHALL be 0.

Structure
REQ-029 A shared package SHALL hold the opcode constants (OP_LOAD, OP_ADD, OP_SUB, OP_CLEAR), the state encoding, and the flag bit indices.
REQ-030 One sub-module, ks_add4_cin, SHALL be used: a combinational 4-bit Kogge-Stone prefix adder with inputs a[3:0], b[3:0], cin and outputs sum[3:0], cout.
REQ-031 ks_add4_cin SHALL be instantiated exactly once and shared by the LO and HI passes.

Verification
REQ-032 Reset check: after reset -> uo_out=0x00, uio_out=0x00, uio_oe=0xF8.
REQ-033 LOAD check: LOAD B=0x3C -> ACC=0x3C, carry=0, zero=0, overflow=0; done pulses for exactly one cycle at E4; busy=1 from E2 to E4.
REQ-034 ADD/SUB check: ACC=0x3C, ADD 0xC4 -> ACC=0x00, carry=1, zero=1, overflow=0; then LOAD 0x50, SUB 0x70 -> ACC=0xE0, carry=0, overflow=0.
REQ-035 Overflow check: LOAD 0x7F, ADD 0x01 -> ACC=0x80, overflow=1, carry=0; LOAD 0x80, SUB 0x01 -> ACC=0x7F, overflow=1, carry=1.
REQ-036 Ignored-strobe check: strobe toggled and ui_in changed during LO/HI -> result unchanged from the original command, and exactly one done pulse.
REQ-037 Abort and CLEAR check: rst_n pulsed low in HI -> all outputs return to reset values immediately; then LOAD 0xAA followed by CLEAR -> ACC=0x00, zero=1.
